// File: rtl/turf_udp_hsk_route.sv
// NCHAN-channel UDP housekeeping reply router: learns per-channel return addresses from snooped
// inbound headers and round-robin muxes outbound streams. Option: TURF_UDP_HSK_DROP_UNLEARNED_EN.
module turf_udp_hsk_route #(
    parameter int unsigned NCHAN        = 2,
    parameter logic [15:0] BASE_PORT    = 16'h5368,
    parameter logic [31:0] DEFAULT_IP   = 32'hC0A80101,
    parameter logic [15:0] DEFAULT_PORT = 16'h5368
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [63:0]         mon_udphdr_tdata,
    input  logic                mon_udphdr_tvalid,
    input  logic                mon_udphdr_tready,
    input  logic [64*NCHAN-1:0] s_tx_tdata,
    input  logic [8*NCHAN-1:0]  s_tx_tkeep,
    input  logic [NCHAN-1:0]    s_tx_tlast,
    input  logic [NCHAN-1:0]    s_tx_tvalid,
    output logic [NCHAN-1:0]    s_tx_tready,
    output logic [63:0]         m_udphdr_tdata,
    output logic                m_udphdr_tvalid,
    input  logic                m_udphdr_tready,
    output logic [63:0]         m_udpdata_tdata,
    output logic [7:0]          m_udpdata_tkeep,
    output logic                m_udpdata_tlast,
    output logic                m_udpdata_tvalid,
    input  logic                m_udpdata_tready,
    output logic [NCHAN-1:0]    learned_o,
    output logic [15:0]         drop_count_o
);

    localparam int unsigned GW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

`ifdef TURF_UDP_HSK_DROP_UNLEARNED_EN
    typedef enum logic [1:0] {StIdle, StHdr, StData, StDrop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;
`endif

    state_e          r_state;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_rr;
    logic [63:0]     r_hdr;
    logic            r_hdr_vld;
    logic [47:0]     r_tbl [NCHAN];
    logic [NCHAN-1:0] r_learned;

    logic [15:0]     w_idx;
    logic            w_learn;
    logic [GW-1:0]   w_grant;
    logic [GW-1:0]   w_rr_next;
    logic            w_sel_valid;
    logic            w_sel_last;

    // Out-of-range destination ports wrap to large values and fall outside the table.
    assign w_idx   = mon_udphdr_tdata[15:0] - BASE_PORT;
    assign w_learn = mon_udphdr_tvalid && mon_udphdr_tready && (w_idx < 16'(NCHAN));

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < int'(NCHAN); i++) r_tbl[i] <= {DEFAULT_IP, DEFAULT_PORT};
            r_learned <= '0;
        end else if (w_learn) begin
            r_tbl[w_idx[GW-1:0]]     <= mon_udphdr_tdata[63:16];
            r_learned[w_idx[GW-1:0]] <= 1'b1;
        end
    end

    // First valid channel at or after r_rr; the descending scan lets the nearest one win.
    always_comb begin
        int unsigned j;
        j       = 0;
        w_grant = '0;
        for (int k = int'(NCHAN) - 1; k >= 0; k--) begin
            j = r_rr + k;
            if (j >= NCHAN) j = j - NCHAN;
            if (s_tx_tvalid[j]) w_grant = GW'(j);
        end
    end

    assign w_rr_next   = (w_grant == GW'(NCHAN - 1)) ? '0 : w_grant + GW'(1);
    assign w_sel_valid = s_tx_tvalid[r_grant];
    assign w_sel_last  = s_tx_tlast[r_grant];

`ifdef TURF_UDP_HSK_DROP_UNLEARNED_EN
    logic [15:0] r_drop_cnt;
    assign drop_count_o = r_drop_cnt;
`else
    assign drop_count_o = '0;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= StIdle;
            r_grant   <= '0;
            r_rr      <= '0;
            r_hdr     <= '0;
            r_hdr_vld <= 1'b0;
`ifdef TURF_UDP_HSK_DROP_UNLEARNED_EN
            r_drop_cnt <= '0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (|s_tx_tvalid) begin
                        r_grant <= w_grant;
                        r_hdr   <= {r_tbl[w_grant], BASE_PORT + 16'(w_grant)};
                        r_rr    <= w_rr_next;
`ifdef TURF_UDP_HSK_DROP_UNLEARNED_EN
                        r_hdr_vld <= r_learned[w_grant];
                        r_state   <= r_learned[w_grant] ? StHdr : StDrop;
`else
                        r_hdr_vld <= 1'b1;
                        r_state   <= StHdr;
`endif
                    end
                end
                StHdr: begin
                    if (m_udphdr_tready) begin
                        r_hdr_vld <= 1'b0;
                        r_state   <= StData;
                    end
                end
                StData: begin
                    if (w_sel_valid && m_udpdata_tready && w_sel_last) r_state <= StIdle;
                end
`ifdef TURF_UDP_HSK_DROP_UNLEARNED_EN
                StDrop: begin
                    if (w_sel_valid && w_sel_last) begin
                        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
                        r_state <= StIdle;
                    end
                end
`endif
                default: r_state <= StIdle;
            endcase
        end
    end

    assign m_udphdr_tdata  = r_hdr;
    assign m_udphdr_tvalid = r_hdr_vld;
    assign m_udpdata_tdata = s_tx_tdata[r_grant*64 +: 64];
    assign m_udpdata_tkeep = s_tx_tkeep[r_grant*8 +: 8];
    assign m_udpdata_tlast = w_sel_last;
    assign learned_o       = r_learned;

    always_comb begin
        s_tx_tready      = '0;
        m_udpdata_tvalid = 1'b0;
        case (r_state)
            StData: begin
                s_tx_tready[r_grant] = m_udpdata_tready;
                m_udpdata_tvalid     = w_sel_valid;
            end
`ifdef TURF_UDP_HSK_DROP_UNLEARNED_EN
            StDrop: s_tx_tready[r_grant] = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_turf_udp_hsk_route.sv
// Directed bench for turf_udp_hsk_route (NCHAN=2): defaults, learning, round-robin,
// backpressure, header snapshot, and the unlearned-drop option when its macro is defined.
module tb_turf_udp_hsk_route;
    localparam int NCHAN  = 2;
    localparam int BUDGET = 200;

    logic                aclk = 1'b0;
    logic                areset;
    logic [63:0]         mon_udphdr_tdata;
    logic                mon_udphdr_tvalid;
    logic                mon_udphdr_tready;
    logic [64*NCHAN-1:0] s_tx_tdata;
    logic [8*NCHAN-1:0]  s_tx_tkeep;
    logic [NCHAN-1:0]    s_tx_tlast;
    logic [NCHAN-1:0]    s_tx_tvalid;
    logic [NCHAN-1:0]    s_tx_tready;
    logic [63:0]         m_udphdr_tdata;
    logic                m_udphdr_tvalid;
    logic                m_udphdr_tready;
    logic [63:0]         m_udpdata_tdata;
    logic [7:0]          m_udpdata_tkeep;
    logic                m_udpdata_tlast;
    logic                m_udpdata_tvalid;
    logic                m_udpdata_tready;
    logic [NCHAN-1:0]    learned_o;
    logic [15:0]         drop_count_o;

    logic [63:0] tx_data  [NCHAN];
    logic [7:0]  tx_keep  [NCHAN];
    logic        tx_last  [NCHAN];
    logic        tx_valid [NCHAN];

    logic [63:0] hq[$];
    logic [63:0] dq[$];
    logic [7:0]  kq[$];
    logic        lq[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 aclk = ~aclk;

    always_comb begin
        for (int i = 0; i < NCHAN; i++) begin
            s_tx_tdata[64*i +: 64] = tx_data[i];
            s_tx_tkeep[8*i +: 8]   = tx_keep[i];
            s_tx_tlast[i]          = tx_last[i];
            s_tx_tvalid[i]         = tx_valid[i];
        end
    end

    turf_udp_hsk_route #(.NCHAN(NCHAN)) dut (
        .aclk              (aclk),
        .areset            (areset),
        .mon_udphdr_tdata  (mon_udphdr_tdata),
        .mon_udphdr_tvalid (mon_udphdr_tvalid),
        .mon_udphdr_tready (mon_udphdr_tready),
        .s_tx_tdata        (s_tx_tdata),
        .s_tx_tkeep        (s_tx_tkeep),
        .s_tx_tlast        (s_tx_tlast),
        .s_tx_tvalid       (s_tx_tvalid),
        .s_tx_tready       (s_tx_tready),
        .m_udphdr_tdata    (m_udphdr_tdata),
        .m_udphdr_tvalid   (m_udphdr_tvalid),
        .m_udphdr_tready   (m_udphdr_tready),
        .m_udpdata_tdata   (m_udpdata_tdata),
        .m_udpdata_tkeep   (m_udpdata_tkeep),
        .m_udpdata_tlast   (m_udpdata_tlast),
        .m_udpdata_tvalid  (m_udpdata_tvalid),
        .m_udpdata_tready  (m_udpdata_tready),
        .learned_o         (learned_o),
        .drop_count_o      (drop_count_o)
    );

    // Inputs change only at posedge+1, so the negedge view equals what the next edge samples.
    always @(negedge aclk) begin
        if (!areset) begin
            if (m_udphdr_tvalid && m_udphdr_tready) hq.push_back(m_udphdr_tdata);
            if (m_udpdata_tvalid && m_udpdata_tready) begin
                dq.push_back(m_udpdata_tdata);
                kq.push_back(m_udpdata_tkeep);
                lq.push_back(m_udpdata_tlast);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] beat(input int ch, input logic [7:0] id, input int b);
        return {8'(ch), id, 16'hBEEF, 32'(b)};
    endfunction

    function automatic logic [63:0] hq_at(input int i);
        return (i < hq.size()) ? hq[i] : 64'hxxxx_xxxx_xxxx_xxxx;
    endfunction

    function automatic logic [63:0] dq_at(input int i);
        return (i < dq.size()) ? dq[i] : 64'hxxxx_xxxx_xxxx_xxxx;
    endfunction

    function automatic logic lq_at(input int i);
        return (i < lq.size()) ? lq[i] : 1'bx;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic clear_q();
        hq.delete(); dq.delete(); kq.delete(); lq.delete();
    endtask

    task automatic learn(input logic [31:0] ip, input logic [15:0] sport, input logic [15:0] dport,
                         input logic rdy);
        mon_udphdr_tdata  = {ip, sport, dport};
        mon_udphdr_tvalid = 1'b1;
        mon_udphdr_tready = rdy;
        tick(1);
        mon_udphdr_tvalid = 1'b0;
        mon_udphdr_tready = 1'b0;
    endtask

    task automatic send_pkt(input int ch, input int nbeats, input logic [7:0] id);
        for (int b = 0; b < nbeats; b++) begin
            int n;
            n            = 0;
            tx_data[ch]  = beat(ch, id, b);
            tx_keep[ch]  = (b == nbeats - 1) ? 8'h0F : 8'hFF;
            tx_last[ch]  = (b == nbeats - 1);
            tx_valid[ch] = 1'b1;
            do begin
                @(negedge aclk);
                n++;
            end while (!s_tx_tready[ch] && n < BUDGET);
            if (!s_tx_tready[ch]) check_eq($sformatf("tx_timeout_ch%0d", ch), n, 0);
            @(posedge aclk);
            #1;
        end
        tx_valid[ch] = 1'b0;
        tx_last[ch]  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  exp_lrn;
        logic [15:0] exp_drop;
        logic [63:0] rr_exp_d [8];
        int          n;

        areset            = 1'b1;
        mon_udphdr_tdata  = '0;
        mon_udphdr_tvalid = 1'b0;
        mon_udphdr_tready = 1'b0;
        m_udphdr_tready   = 1'b1;
        m_udpdata_tready  = 1'b1;
        for (int i = 0; i < NCHAN; i++) begin
            tx_data[i] = '0; tx_keep[i] = '0; tx_last[i] = 1'b0; tx_valid[i] = 1'b0;
        end
        tick(2);
        @(negedge aclk);
        check_eq("rst_learned", learned_o, 2'b00);
        check_eq("rst_drop", drop_count_o, 16'd0);
        check_eq("rst_hvalid", m_udphdr_tvalid, 1'b0);
        check_eq("rst_dvalid", m_udpdata_tvalid, 1'b0);
        check_eq("rst_tready", s_tx_tready, 2'b00);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        tick(1);

        // Unlearned ch1: default address, or dropped when the option is built.
        clear_q();
        send_pkt(1, 3, 8'h01);
        tick(2);
`ifdef TURF_UDP_HSK_DROP_UNLEARNED_EN
        check_eq("drop_nohdr", hq.size(), 0);
        check_eq("drop_nodata", dq.size(), 0);
        check_eq("drop_cnt", drop_count_o, 16'd1);
        learn(32'hC0A80101, 16'h5368, 16'h5369, 1'b1);
        exp_lrn  = 2'b10;
        exp_drop = 16'd1;
`else
        check_eq("def_hcnt", hq.size(), 1);
        check_eq("def_hdr", hq_at(0), 64'hC0A80101_5368_5369);
        check_eq("def_dcnt", dq.size(), 3);
        for (int b = 0; b < 3; b++) begin
            check_eq($sformatf("def_d%0d", b), dq_at(b), beat(1, 8'h01, b));
            check_eq($sformatf("def_l%0d", b), lq_at(b), b == 2);
        end
        check_eq("def_keep", (kq.size() == 3) ? kq[2] : 8'hxx, 8'h0F);
        exp_lrn  = 2'b00;
        exp_drop = 16'd0;
`endif
        check_eq("def_learned", learned_o, exp_lrn);

        // Learning: one cycle of latency, non-handshakes and out-of-range ports ignored.
        mon_udphdr_tdata  = {32'h0A000005, 16'h1234, 16'h5368};
        mon_udphdr_tvalid = 1'b1;
        mon_udphdr_tready = 1'b1;
        @(negedge aclk);
        check_eq("lrn_pre", learned_o, exp_lrn);
        tick(1);
        mon_udphdr_tvalid = 1'b0;
        mon_udphdr_tready = 1'b0;
        @(negedge aclk);
        exp_lrn = exp_lrn | 2'b01;
        check_eq("lrn_post", learned_o, exp_lrn);
        tick(1);
        learn(32'hDEADBEEF, 16'h1111, 16'h536A, 1'b1);
        learn(32'hDEADBEEF, 16'h2222, 16'h5367, 1'b1);
        learn(32'hDEADBEEF, 16'h3333, 16'h5369, 1'b0);
        tick(1);
        check_eq("lrn_ignored", learned_o, exp_lrn);
        clear_q();
        send_pkt(0, 2, 8'h02);
        tick(2);
        check_eq("lrn_hdr", hq_at(0), 64'h0A000005_1234_5368);

        // Round-robin: pointer sits at ch1 after the last ch0 grant.
        clear_q();
        fork
            begin send_pkt(0, 2, 8'hA0); send_pkt(0, 2, 8'hB0); end
            begin send_pkt(1, 2, 8'hC0); send_pkt(1, 2, 8'hD0); end
        join
        tick(2);
        check_eq("rr_hcnt", hq.size(), 4);
        check_eq("rr_h0", hq_at(0), 64'hC0A80101_5368_5369);
        check_eq("rr_h1", hq_at(1), 64'h0A000005_1234_5368);
        check_eq("rr_h2", hq_at(2), 64'hC0A80101_5368_5369);
        check_eq("rr_h3", hq_at(3), 64'h0A000005_1234_5368);
        rr_exp_d = '{beat(1, 8'hC0, 0), beat(1, 8'hC0, 1), beat(0, 8'hA0, 0), beat(0, 8'hA0, 1),
                     beat(1, 8'hD0, 0), beat(1, 8'hD0, 1), beat(0, 8'hB0, 0), beat(0, 8'hB0, 1)};
        check_eq("rr_dcnt", dq.size(), 8);
        for (int i = 0; i < 8; i++) check_eq($sformatf("rr_d%0d", i), dq_at(i), rr_exp_d[i]);

        // Backpressure on header, then toggling data ready.
        clear_q();
        m_udphdr_tready  = 1'b0;
        m_udpdata_tready = 1'b0;
        fork
            send_pkt(1, 3, 8'h10);
            begin
                @(negedge aclk);
                check_eq("bp_idle_hvalid", m_udphdr_tvalid, 1'b0);
                for (int i = 0; i < 5; i++) begin
                    @(negedge aclk);
                    check_eq($sformatf("bp_hvalid%0d", i), m_udphdr_tvalid, 1'b1);
                    check_eq($sformatf("bp_hdr%0d", i), m_udphdr_tdata, 64'hC0A80101_5368_5369);
                    check_eq($sformatf("bp_tready%0d", i), s_tx_tready, 2'b00);
                end
                @(posedge aclk);
                #1;
                m_udphdr_tready = 1'b1;
                for (int i = 0; i < 20; i++) begin
                    @(posedge aclk);
                    #1;
                    m_udpdata_tready = ~m_udpdata_tready;
                end
                m_udpdata_tready = 1'b1;
            end
        join
        tick(2);
        check_eq("bp_hcnt", hq.size(), 1);
        check_eq("bp_dcnt", dq.size(), 3);
        for (int b = 0; b < 3; b++) check_eq($sformatf("bp_d%0d", b), dq_at(b), beat(1, 8'h10, b));

        // Snapshot: a learn for ch0 during its DATA phase affects only the next packet.
        clear_q();
        fork
            send_pkt(0, 4, 8'h30);
            begin
                n = 0;
                do begin
                    @(negedge aclk);
                    n++;
                end while (!m_udpdata_tvalid && n < 50);
                if (!m_udpdata_tvalid) check_eq("snap_timeout", n, 0);
                @(posedge aclk);
                #1;
                learn(32'h0B0B0B0B, 16'h4321, 16'h5368, 1'b1);
            end
        join
        tick(2);
        send_pkt(0, 1, 8'h31);
        tick(2);
        check_eq("snap_hdr_old", hq_at(0), 64'h0A000005_1234_5368);
        check_eq("snap_hdr_new", hq_at(1), 64'h0B0B0B0B_4321_5368);
        check_eq("snap_dcnt", dq.size(), 5);
        check_eq("snap_single_last", lq_at(4), 1'b1);
        check_eq("end_drop", drop_count_o, exp_drop);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
